conv2d_stream_engine: RTL and testbench

Parametrised 2-D convolution engine and successor to the fixed 8x8 / 3x3 / 2-filter convolution layer. It takes a frame as a valid/ready pixel stream, buffers it internally and computes every output position of every filter with zero padding and a runtime-loadable weight/bias memory. Each result goes through bias add, scale and ReLU, then leaves on a valid/ready result stream. It sits between the top-level image loader and the ReLU/maxpool/linear chain.

---
 rtl/conv_pkg.sv | 39 +++
 rtl/conv_window_addr.sv | 37 +++
 rtl/conv2d_stream_engine.sv | 215 +++++++++++++++++++++
 tb/tb_conv2d_stream_engine.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming 2-D convolution engine.
// Holds the control state encoding, width helpers and the output saturation stage.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MAC  = 3'd2,
    EMIT = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam int SAT_W = 32;

  // Index width for n entries, never narrower than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int out_dim(input int img, input int k, input int pad);
    return img + 2 * pad - k + 1;
  endfunction

  function automatic logic [SAT_W-1:0] sat_relu(input logic signed [63:0] acc,
                                                input int shift, input int data_w);
    logic signed [63:0] sh;
    logic        [63:0] max_v;
    max_v = (64'd1 << data_w) - 64'd1;
    sh    = acc >>> shift;
    if (acc < 64'sd0) begin
      return '0;
    end else if (sh > $signed(max_v)) begin
      return SAT_W'(max_v);
    end else begin
      return SAT_W'(sh);
    end
  endfunction

endpackage

// File: rtl/conv_window_addr.sv
// Maps an output position plus kernel tap to a raster frame address.
// in_frame is low for taps that land in the zero-padding border.
module conv_window_addr
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PAD   = 1,
  parameter int OY_W  = 3,
  parameter int OX_W  = 3,
  parameter int KC_W  = 2,
  parameter int FA_W  = 6
) (
  input  logic [OY_W-1:0] oy,
  input  logic [OX_W-1:0] ox,
  input  logic [KC_W-1:0] ky,
  input  logic [KC_W-1:0] kx,
  output logic [FA_W-1:0] addr,
  output logic            in_frame
);

  int iy_s;
  int ix_s;

  // Signed input coordinate, bounds test and raster address.
  always_comb begin
    iy_s     = int'(oy) + int'(ky) - PAD;
    ix_s     = int'(ox) + int'(kx) - PAD;
    in_frame = (iy_s >= 0) && (iy_s < IMG_H) && (ix_s >= 0) && (ix_s < IMG_W);
    if (in_frame) begin
      addr = FA_W'(iy_s * IMG_W + ix_s);
    end else begin
      addr = '0;
    end
  end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming 2-D convolution: buffers a frame, then emits every (position, filter)
// result through bias add, shift, ReLU and saturation on a valid/ready stream.
module conv2d_stream_engine
  import conv_pkg::*;
#(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int K          = 3,
  parameter int PAD        = 1,
  parameter int N_FILT     = 2,
  parameter int DATA_W     = 8,
  parameter int WT_W       = 8,
  parameter int ACC_W      = 20,
  parameter int SHIFT      = 3,
  parameter int BIAS_SHIFT = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             pix_valid,
  input  logic [DATA_W-1:0]                pix_data,
  output logic                             pix_ready,
  input  logic                             wt_we,
  input  logic [cw(N_FILT*(K*K+1))-1:0]    wt_addr,
  input  logic [WT_W-1:0]                  wt_data,
  output logic                             out_valid,
  output logic [DATA_W-1:0]                out_data,
  output logic [cw(N_FILT)-1:0]            out_filt,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             done
);

  localparam int TAPS   = K * K;
  localparam int OUT_W  = out_dim(IMG_W, K, PAD);
  localparam int OUT_H  = out_dim(IMG_H, K, PAD);
  localparam int N_PIX  = IMG_W * IMG_H;
  localparam int N_WT   = N_FILT * (TAPS + 1);
  localparam int WA_W   = cw(N_WT);
  localparam int FILT_W = cw(N_FILT);
  localparam int FA_W   = cw(N_PIX);
  localparam int OX_W   = cw(OUT_W);
  localparam int OY_W   = cw(OUT_H);
  localparam int KC_W   = cw(K);

  localparam logic [FA_W-1:0]   PIX_LAST  = FA_W'(N_PIX - 1);
  localparam logic [OX_W-1:0]   OX_LAST   = OX_W'(OUT_W - 1);
  localparam logic [OY_W-1:0]   OY_LAST   = OY_W'(OUT_H - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(N_FILT - 1);
  localparam logic [KC_W-1:0]   KC_LAST   = KC_W'(K - 1);

  // An unsigned pixel times a signed weight fits DATA_W+WT_W signed bits.
  if (ACC_W < DATA_W + WT_W + $clog2(TAPS)) begin : g_acc_w_chk
    $error("conv2d_stream_engine: ACC_W too narrow for K*K accumulations");
  end

  state_t                   state_r, state_nx_s;
  logic [DATA_W-1:0]        frame_r [N_PIX];
  logic signed [WT_W-1:0]   wmem_r  [N_WT];
  logic [FA_W-1:0]          pix_cnt_r;
  logic [OY_W-1:0]          oy_r;
  logic [OX_W-1:0]          ox_r;
  logic [FILT_W-1:0]        filt_r;
  logic [KC_W-1:0]          ky_r, kx_r;
  logic                     bias_ph_r;
  logic signed [ACC_W-1:0]  acc_r;

  logic                     pix_fire_s, out_fire_s, pix_last_s, res_last_s;
  logic [FA_W-1:0]          win_addr_s;
  logic                     in_frame_s;
  logic [WA_W-1:0]          tap_addr_s, bias_addr_s;
  logic [DATA_W-1:0]        pix_s;
  logic signed [DATA_W+WT_W:0] prod_s;
  logic signed [ACC_W-1:0]  res_sum_s;
  logic [DATA_W-1:0]        res_val_s;

  conv_window_addr #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PAD   (PAD),
    .OY_W  (OY_W),
    .OX_W  (OX_W),
    .KC_W  (KC_W),
    .FA_W  (FA_W)
  ) u_win (
    .oy       (oy_r),
    .ox       (ox_r),
    .ky       (ky_r),
    .kx       (kx_r),
    .addr     (win_addr_s),
    .in_frame (in_frame_s)
  );

  // Handshakes, memory addressing, tap product and the finished result value.
  always_comb begin
    pix_fire_s  = pix_valid & pix_ready;
    out_fire_s  = out_valid & out_ready;
    pix_last_s  = (pix_cnt_r == PIX_LAST);
    res_last_s  = (filt_r == FILT_LAST) && (ox_r == OX_LAST) && (oy_r == OY_LAST);
    tap_addr_s  = WA_W'(int'(filt_r) * (TAPS + 1) + int'(ky_r) * K + int'(kx_r));
    bias_addr_s = WA_W'(int'(filt_r) * (TAPS + 1) + TAPS);
    pix_s       = in_frame_s ? frame_r[win_addr_s] : '0;
    prod_s      = $signed({1'b0, pix_s}) * wmem_r[tap_addr_s];
    res_sum_s   = acc_r + (ACC_W'(wmem_r[bias_addr_s]) <<< BIAS_SHIFT);
    res_val_s   = DATA_W'(sat_relu(64'(res_sum_s), SHIFT, DATA_W));
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    state_nx_s = start ? LOAD : IDLE;
      LOAD:    state_nx_s = (pix_fire_s && pix_last_s) ? MAC : LOAD;
      MAC:     state_nx_s = bias_ph_r ? EMIT : MAC;
      EMIT: begin
        if (out_fire_s) begin
          state_nx_s = res_last_s ? FIN : MAC;
        end else begin
          state_nx_s = EMIT;
        end
      end
      FIN:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register; status outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pix_ready <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      pix_ready <= (state_nx_s == LOAD);
      out_valid <= (state_nx_s == EMIT);
      busy      <= (state_nx_s != IDLE);
      done      <= (state_nx_s == FIN);
    end
  end

  // Frame buffer and weight memory keep their contents across reset.
  always_ff @(posedge clk) begin
    if (rst_n && pix_fire_s) begin
      frame_r[pix_cnt_r] <= pix_data;
    end
    if (rst_n && wt_we && (state_r == IDLE) && (int'(wt_addr) < N_WT)) begin
      wmem_r[wt_addr] <= wt_data;
    end
  end

  // Load counter, tap walk, accumulator and output ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_cnt_r <= '0;
      oy_r      <= '0;
      ox_r      <= '0;
      filt_r    <= '0;
      ky_r      <= '0;
      kx_r      <= '0;
      bias_ph_r <= 1'b0;
      acc_r     <= '0;
      out_data  <= '0;
      out_filt  <= '0;
    end else begin
      case (state_r)
        LOAD: begin
          if (pix_fire_s) begin
            pix_cnt_r <= pix_last_s ? '0 : pix_cnt_r + FA_W'(1);
          end
        end
        MAC: begin
          if (bias_ph_r) begin
            out_data  <= res_val_s;
            out_filt  <= filt_r;
            bias_ph_r <= 1'b0;
          end else begin
            acc_r <= acc_r + ACC_W'(prod_s);
            if (kx_r == KC_LAST) begin
              kx_r <= '0;
              if (ky_r == KC_LAST) begin
                ky_r      <= '0;
                bias_ph_r <= 1'b1;
              end else begin
                ky_r <= ky_r + KC_W'(1);
              end
            end else begin
              kx_r <= kx_r + KC_W'(1);
            end
          end
        end
        EMIT: begin
          if (out_fire_s) begin
            acc_r <= '0;
            if (filt_r == FILT_LAST) begin
              filt_r <= '0;
              if (ox_r == OX_LAST) begin
                ox_r <= '0;
                oy_r <= (oy_r == OY_LAST) ? '0 : oy_r + OY_W'(1);
              end else begin
                ox_r <= ox_r + OX_W'(1);
              end
            end else begin
              filt_r <= filt_r + FILT_W'(1);
            end
          end
        end
        default: acc_r <= acc_r;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Directed bench for conv2d_stream_engine at default parameters (SHIFT=3, BIAS_SHIFT=3).
module tb_conv2d_stream_engine;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int K     = 3;
  localparam int PAD   = 1;
  localparam int OUT_W = 8;
  localparam int N_RES = 128;

  logic       clk = 1'b0;
  logic       rst_n, start, pix_valid, wt_we, out_ready;
  logic [7:0] pix_data, wt_data, out_data;
  logic [4:0] wt_addr;
  logic [0:0] out_filt;
  logic       pix_ready, out_valid, busy, done;

  always #5 clk = ~clk;

  conv2d_stream_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .wt_we     (wt_we),
    .wt_addr   (wt_addr),
    .wt_data   (wt_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_filt  (out_filt),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int wmod [2][9];
  int bmod [2];
  int pmode  = 0;
  int pconst = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pix_at(input int y, input int x);
    if (y < 0 || y >= IMG_H || x < 0 || x >= IMG_W) return 0;
    return (pmode == 1) ? y * IMG_W + x : pconst;
  endfunction

  // Reference convolution with zero padding, bias<<3, ReLU, >>3, saturate to 255.
  function automatic int expect_res(input int oy, input int ox, input int f);
    int r;
    r = bmod[f] * 8;
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++)
        r += pix_at(oy + ky - PAD, ox + kx - PAD) * wmod[f][ky * K + kx];
    if (r < 0) return 0;
    r = r >>> 3;
    return (r > 255) ? 255 : r;
  endfunction

  task automatic write_wt(input int a, input int d);
    wt_we   = 1'b1;
    wt_addr = 5'(a);
    wt_data = 8'(d);
    tick();
    wt_we   = 1'b0;
  endtask

  task automatic set_filter(input int f, input int w, input int b);
    for (int t = 0; t < 9; t++) begin
      write_wt(f * 10 + t, w);
      wmod[f][t] = w;
    end
    write_wt(f * 10 + 9, b);
    bmod[f] = b;
  endtask

  task automatic set_tap(input int f, input int t, input int w);
    write_wt(f * 10 + t, w);
    wmod[f][t] = w;
  endtask

  task automatic send_frame(input int gap, input bit inj);
    int idx   = 0;
    int guard = 0;
    bit fire;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (idx < IMG_W * IMG_H && guard < 4000) begin
      pix_valid = 1'b1;
      pix_data  = 8'(pix_at(idx / IMG_W, idx % IMG_W));
      if (inj && idx >= 5) begin
        wt_we   = 1'b1;
        wt_addr = 5'd0;
        wt_data = 8'd100;
      end
      fire = pix_ready;
      tick();
      guard++;
      if (fire) begin
        idx++;
        if (gap > 0 && idx < IMG_W * IMG_H) begin
          pix_valid = 1'b0;
          repeat (gap) tick();
        end
      end
    end
    pix_valid = 1'b0;
    wt_we     = 1'b0;
    if (guard >= 4000) check_eq("load_timeout", idx, IMG_W * IMG_H);
    check_eq("pix_ready_drop", int'(pix_ready), 0);
    check_eq("busy_after_load", int'(busy), 1);
  endtask

  task automatic collect(input int stall_idx, input bit chk_timing, input bit hand);
    int n     = 0;
    int cyc   = 0;
    int first = -1;
    int oy, ox, f, e;
    out_ready = 1'b1;
    while (n < N_RES && cyc < 20000) begin
      if (out_valid) begin
        if (first < 0) first = cyc;
        oy = (n / 2) / OUT_W;
        ox = (n / 2) % OUT_W;
        f  = n % 2;
        e  = expect_res(oy, ox, f);
        if (n == stall_idx) begin
          out_ready = 1'b0;
          repeat (5) begin
            tick();
            cyc++;
            check_eq("stall_valid", int'(out_valid), 1);
            check_eq("stall_data", int'(out_data), e);
            check_eq("stall_filt", int'(out_filt), f);
          end
          out_ready = 1'b1;
        end
        check_eq($sformatf("res_data[%0d]", n), int'(out_data), e);
        check_eq($sformatf("res_filt[%0d]", n), int'(out_filt), f);
        if (hand && n == 0)  check_eq("corner_40", int'(out_data), 40);
        if (hand && n == 1)  check_eq("bias_only_5", int'(out_data), 5);
        if (hand && n == 2)  check_eq("edge_60", int'(out_data), 60);
        if (hand && n == 18) check_eq("interior_90", int'(out_data), 90);
        n++;
      end
      tick();
      cyc++;
    end
    check_eq("result_count", n, N_RES);
    if (chk_timing) begin
      check_eq("first_latency", first, 10);
      check_eq("frame_cycles", cyc, N_RES * 11);
    end
    check_eq("done_pulse", int'(done), 1);
    check_eq("no_extra_valid", int'(out_valid), 0);
    tick();
    check_eq("done_single", int'(done), 0);
    check_eq("busy_idle", int'(busy), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = 8'd0;
    wt_we = 1'b0; wt_addr = 5'd0; wt_data = 8'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pix_ready", int'(pix_ready), 0);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_out_data", int'(out_data), 0);
    check_eq("rst_out_filt", int'(out_filt), 0);
    rst_n = 1'b1;
    tick();

    // Flat 10s: f0 taps 8 -> 40/60/90, f1 bias-only -> 5.
    set_filter(0, 8, 0);
    set_filter(1, 0, 5);
    pmode = 0; pconst = 10;
    send_frame(0, 1'b0);
    collect(-1, 1'b1, 1'b1);

    // Saturation at 255.
    set_filter(0, 16, 0);
    set_filter(1, 16, 0);
    pconst = 255;
    send_frame(0, 1'b0);
    collect(-1, 1'b0, 1'b0);

    // Negative sums clamp to 0; zero taps with bias give 5.
    set_filter(0, -1, 0);
    set_filter(1, 0, 5);
    pconst = 200;
    send_frame(0, 1'b0);
    collect(-1, 1'b0, 1'b0);

    // Ramp frame probes addressing; back-pressure at result 7.
    set_filter(0, 0, 0);
    set_filter(1, 0, 0);
    set_tap(0, 4, 8);
    set_tap(1, 8, 8);
    pmode = 1;
    send_frame(0, 1'b0);
    collect(7, 1'b0, 1'b0);

    // Reset mid-MAC, then a clean rerun of the first frame.
    set_filter(0, 8, 0);
    set_filter(1, 0, 5);
    pmode = 0; pconst = 10;
    send_frame(0, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_out_valid", int'(out_valid), 0);
    check_eq("midrst_pix_ready", int'(pix_ready), 0);
    check_eq("midrst_out_data", int'(out_data), 0);
    tick();
    send_frame(0, 1'b0);
    collect(-1, 1'b1, 1'b1);

    // Weight write during LOAD is dropped; pixel gaps do not change results.
    send_frame(3, 1'b1);
    collect(-1, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
